light_sequencer: RTL and testbench

Intersection phase controller for the traffic light design. It steps through the main-street, side-street and pedestrian phases. For each phase it programs and starts the shared `Timer` by driving `value` and pulsing `start_timer`, then waits for `expired` and decides the next phase from the side-street sensor and any latched walk request. It drives the lamp and walk outputs directly and is the only master of the `Timer` control inputs.

---
 rtl/traffic_pkg.sv | 24 ++
 rtl/request_latch.sv | 29 ++
 rtl/light_sequencer.sv | 126 ++++++++++++
 tb/tb_light_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: types and constants shared by the traffic light design.
//   state_e        - sequencer phase encoding
//   RED/YEL/GRN    - one-hot lamp codes, {red, yellow, green}
//   DEF_T_*        - default phase intervals in timer ticks
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_G,
        MAIN_Y,
        WALK,
        SIDE_G,
        SIDE_GX,
        SIDE_Y
    } state_e;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [3:0] DEF_T_BASE = 4'd6;
    localparam logic [3:0] DEF_T_EXT  = 4'd3;
    localparam logic [3:0] DEF_T_YEL  = 4'd2;

endpackage

// File: rtl/request_latch.sv
// request_latch: pedestrian walk-pending flag.
//   clock       - system clock
//   reset_sync  - synchronous active-high reset, clears the flag
//   set_i       - walk button (any 1-cycle pulse)
//   block_i     - high during WALK; requests are dropped
//   clear_i     - high on the edge entering WALK; beats a simultaneous set
//   pending_o   - latched request
module request_latch (
    input  logic clock,
    input  logic reset_sync,
    input  logic set_i,
    input  logic block_i,
    input  logic clear_i,
    output logic pending_o
);

    logic pending_q;

    always_ff @(posedge clock) begin
        if (reset_sync || clear_i) begin
            pending_q <= 1'b0;
        end else if (set_i && !block_i) begin
            pending_q <= 1'b1;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/light_sequencer.sv
// light_sequencer: intersection phase controller.
//   clock, reset_sync - system clock, synchronous active-high reset
//   sensor            - side-street vehicle present, sampled on deciding edges
//   walk_request      - pedestrian button, latched in request_latch
//   expired           - Timer reports the programmed interval has elapsed
//   start_timer       - 1-cycle load/start pulse after every phase entry
//   value             - interval for the current phase, held for the phase
//   main_lights       - main street lamps {red, yellow, green}
//   side_lights       - side street lamps {red, yellow, green}
//   walk              - pedestrian walk lamp
// All outputs are registered.
module light_sequencer
    import traffic_pkg::*;
#(
    parameter logic [3:0] T_BASE = DEF_T_BASE,
    parameter logic [3:0] T_EXT  = DEF_T_EXT,
    parameter logic [3:0] T_YEL  = DEF_T_YEL
) (
    input  logic       clock,
    input  logic       reset_sync,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] value,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk
);

    state_e     state_q, state_d;
    logic       start_q, start_d;
    logic [3:0] value_q, value_d;
    logic [2:0] main_q, main_d;
    logic [2:0] side_q, side_d;
    logic       walk_q, walk_d;
    // Low only in reset; forces a MAIN_G entry (with start pulse) on the
    // first edge after release.
    logic       run_q;

    logic       pending;
    logic       enter;
    logic       clear_walk;
    state_e     nxt;

    request_latch u_request_latch (
        .clock      (clock),
        .reset_sync (reset_sync),
        .set_i      (walk_request),
        .block_i    (state_q == WALK),
        .clear_i    (clear_walk),
        .pending_o  (pending)
    );

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        value_d    = value_q;
        main_d     = main_q;
        side_d     = side_q;
        walk_d     = walk_q;
        enter      = 1'b0;
        nxt        = state_q;
        clear_walk = 1'b0;

        if (!run_q) begin
            enter = 1'b1;
            nxt   = MAIN_G;
        end else if (expired && !start_q) begin
            // expired is meaningless while the Timer is still loading.
            enter = 1'b1;
            case (state_q)
                MAIN_G:  nxt = (sensor || pending) ? MAIN_Y : MAIN_G;
                MAIN_Y:  nxt = pending ? WALK : SIDE_G;
                WALK:    nxt = sensor ? SIDE_G : MAIN_G;
                SIDE_G:  nxt = sensor ? SIDE_GX : SIDE_Y;
                SIDE_GX: nxt = SIDE_Y;
                SIDE_Y:  nxt = MAIN_G;
                default: nxt = MAIN_G;
            endcase
        end

        if (enter) begin
            state_d    = nxt;
            start_d    = 1'b1;
            clear_walk = (nxt == WALK);
            walk_d     = 1'b0;
            case (nxt)
                MAIN_G:  begin main_d = GRN; side_d = RED; value_d = T_BASE; end
                MAIN_Y:  begin main_d = YEL; side_d = RED; value_d = T_YEL;  end
                WALK:    begin main_d = RED; side_d = RED; value_d = T_EXT; walk_d = 1'b1; end
                SIDE_G:  begin main_d = RED; side_d = GRN; value_d = T_BASE; end
                SIDE_GX: begin main_d = RED; side_d = GRN; value_d = T_EXT;  end
                SIDE_Y:  begin main_d = RED; side_d = YEL; value_d = T_YEL;  end
                default: begin main_d = GRN; side_d = RED; value_d = T_BASE; end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset_sync) begin
            state_q <= MAIN_G;
            start_q <= 1'b0;
            value_q <= '0;
            main_q  <= GRN;
            side_q  <= RED;
            walk_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            value_q <= value_d;
            main_q  <= main_d;
            side_q  <= side_d;
            walk_q  <= walk_d;
            run_q   <= 1'b1;
        end
    end

    assign start_timer = start_q;
    assign value       = value_q;
    assign main_lights = main_q;
    assign side_lights = side_q;
    assign walk        = walk_q;

endmodule

// File: tb/tb_light_sequencer.sv
module tb_light_sequencer;

    logic       clock = 1'b0;
    logic       reset_sync = 1'b1;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       force_exp = 1'b0;
    logic       expired;
    logic       start_timer;
    logic [3:0] value;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clock = ~clock;

    light_sequencer #(
        .T_BASE (4'd6),
        .T_EXT  (4'd3),
        .T_YEL  (4'd2)
    ) dut (
        .clock        (clock),
        .reset_sync   (reset_sync),
        .sensor       (sensor),
        .walk_request (walk_request),
        .expired      (expired),
        .start_timer  (start_timer),
        .value        (value),
        .main_lights  (main_lights),
        .side_lights  (side_lights),
        .walk         (walk)
    );

    // Behavioural Timer: loads on the start pulse, counts down, then holds expired.
    logic [3:0] tcnt   = 4'd0;
    logic       tarmed = 1'b0;
    always @(posedge clock) begin
        if (reset_sync) begin
            tarmed <= 1'b0;
            tcnt   <= 4'd0;
        end else if (start_timer) begin
            tarmed <= 1'b1;
            tcnt   <= value;
        end else if (tcnt != 4'd0) begin
            tcnt <= tcnt - 4'd1;
        end
    end
    assign expired = force_exp | (tarmed && (tcnt == 4'd0));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase table + transition rules.
    localparam int P_MG = 0, P_MY = 1, P_WK = 2, P_SG = 3, P_SX = 4, P_SY = 5;
    logic [2:0] tab_main [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] tab_side [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
    logic       tab_walk [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] tab_val  [6] = '{4'd6, 4'd2, 4'd3, 4'd6, 4'd3, 4'd2};

    function automatic int next_phase(input int p, input bit s, input bit pend);
        case (p)
            P_MG:    return (s || pend) ? P_MY : P_MG;
            P_MY:    return pend ? P_WK : P_SG;
            P_WK:    return s ? P_SG : P_MG;
            P_SG:    return s ? P_SX : P_SY;
            P_SX:    return P_SY;
            default: return P_MG;
        endcase
    endfunction

    int         m_phase = P_MG;
    bit         m_pend = 0, m_start = 0, m_booted = 0, m_walk = 0;
    logic [2:0] m_main = 3'b001, m_side = 3'b100;
    logic [3:0] m_value = 4'd0;

    always @(posedge clock) begin
        bit dec;
        bit req;
        int np;
        req = walk_request && (m_phase != P_WK);
        if (reset_sync) begin
            m_phase = P_MG; m_pend = 0; m_start = 0; m_booted = 0;
            m_main = 3'b001; m_side = 3'b100; m_walk = 0; m_value = 4'd0;
        end else begin
            if (!m_booted) begin
                dec = 1; np = P_MG;
            end else begin
                dec = expired && !m_start;
                np  = next_phase(m_phase, sensor, m_pend);
            end
            m_booted = 1;
            if (dec) begin
                m_pend  = (np == P_WK) ? 1'b0 : (m_pend | req);
                m_phase = np;
                m_main  = tab_main[np];
                m_side  = tab_side[np];
                m_walk  = tab_walk[np];
                m_value = tab_val[np];
                m_start = 1;
            end else begin
                m_pend  = m_pend | req;
                m_start = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check_eq("no_x", 32'($isunknown({start_timer, value, main_lights, side_lights, walk})), 32'd0);
            check_eq("main", 32'(main_lights), 32'(m_main));
            check_eq("side", 32'(side_lights), 32'(m_side));
            check_eq("walk", 32'(walk), 32'(m_walk));
            check_eq("start", 32'(start_timer), 32'(m_start));
            check_eq("value", 32'(value), 32'(m_value));
            check_eq("both_nonred", 32'((main_lights != 3'b100) && (side_lights != 3'b100)), 32'd0);
        end
    end

    task automatic wait_pulse(output bit ok);
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (start_timer === 1'b1) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic expect_phase(input string tag, input logic [2:0] mn, input logic [2:0] sd,
                                input logic wk, input logic [3:0] v);
        bit ok;
        wait_pulse(ok);
        check_eq({tag, "_seen"}, 32'(ok), 32'd1);
        check_eq({tag, "_main"}, 32'(main_lights), 32'(mn));
        check_eq({tag, "_side"}, 32'(side_lights), 32'(sd));
        check_eq({tag, "_walk"}, 32'(walk), 32'(wk));
        check_eq({tag, "_value"}, 32'(value), 32'(v));
    endtask

    task automatic reset_values(input string tag);
        check_eq({tag, "_main"}, 32'(main_lights), 32'h1);
        check_eq({tag, "_side"}, 32'(side_lights), 32'h4);
        check_eq({tag, "_walk"}, 32'(walk), 32'd0);
        check_eq({tag, "_start"}, 32'(start_timer), 32'd0);
        check_eq({tag, "_value"}, 32'(value), 32'd0);
    endtask

    initial begin
        int pulses;
        int walks;
        bit ok;
        logic [3:0] seq5 [5] = '{4'd6, 4'd2, 4'd6, 4'd3, 4'd2};

        // 1. reset and release
        reset_sync = 1'b1;
        @(posedge clock);
        chk_en = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_values("rst");
        reset_sync = 1'b0;
        @(negedge clock);
        check_eq("boot_start", 32'(start_timer), 32'd1);
        check_eq("boot_value", 32'(value), 32'd6);
        check_eq("boot_main", 32'(main_lights), 32'h1);
        @(negedge clock);
        check_eq("boot_pulse_len", 32'(start_timer), 32'd0);

        // 2. idle main green restarts in T_BASE slices
        pulses = 0;
        for (int i = 0; i < 23; i++) begin
            @(negedge clock);
            if (start_timer) begin
                pulses++;
                check_eq("idle_value", 32'(value), 32'd6);
            end
            check_eq("idle_main", 32'(main_lights), 32'h1);
        end
        check_eq("idle_pulses", 32'(pulses), 32'd3);

        // 3. sensor held: full side cycle
        sensor = 1'b1;
        expect_phase("s3_my",  3'b010, 3'b100, 1'b0, 4'd2);
        expect_phase("s3_sg",  3'b100, 3'b001, 1'b0, 4'd6);
        expect_phase("s3_sgx", 3'b100, 3'b001, 1'b0, 4'd3);
        expect_phase("s3_sy",  3'b100, 3'b010, 1'b0, 4'd2);
        expect_phase("s3_mg",  3'b001, 3'b100, 1'b0, 4'd6);

        // 4. walk request mid MAIN_G, second request during WALK dropped
        sensor = 1'b0;
        repeat (3) @(negedge clock);
        walk_request = 1'b1;
        @(negedge clock);
        walk_request = 1'b0;
        expect_phase("s4_my", 3'b010, 3'b100, 1'b0, 4'd2);
        expect_phase("s4_wk", 3'b100, 3'b100, 1'b1, 4'd3);
        walk_request = 1'b1;
        @(negedge clock);
        walk_request = 1'b0;
        expect_phase("s4_mg",  3'b001, 3'b100, 1'b0, 4'd6);
        expect_phase("s4_mg2", 3'b001, 3'b100, 1'b0, 4'd6);

        // 5. expired held high: one state per 2 cycles
        reset_sync = 1'b1;
        repeat (2) @(negedge clock);
        reset_sync = 1'b0;
        sensor = 1'b1;
        force_exp = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            check_eq("fast_start", 32'(start_timer), 32'((k % 2) == 0));
            if ((k % 2) == 0)
                check_eq("fast_value", 32'(value), 32'(seq5[(k / 2) % 5]));
        end

        // 6. reset during SIDE_GX with walk pending
        force_exp = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (start_timer && value == 4'd3 && side_lights == 3'b001) begin
                ok = 1;
                break;
            end
        end
        check_eq("s6_sgx_seen", 32'(ok), 32'd1);
        walk_request = 1'b1;
        @(negedge clock);
        walk_request = 1'b0;
        reset_sync = 1'b1;
        @(negedge clock);
        reset_values("s6_rst");
        reset_sync = 1'b0;
        sensor = 1'b0;
        @(negedge clock);
        check_eq("s6_restart_start", 32'(start_timer), 32'd1);
        check_eq("s6_restart_value", 32'(value), 32'd6);
        walks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (walk) walks++;
        end
        check_eq("s6_no_walk", 32'(walks), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 7) == 0) sensor = ~sensor;
            walk_request = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) force_exp = ~force_exp;
            reset_sync = ($urandom_range(0, 499) == 0);
        end
        reset_sync = 1'b0;
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
